// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, register-file geometry, FSM encoding and starve limit
package rf_pkg;
   localparam int ADDR_W     = 5;
   localparam int DATA_W     = 32;
   localparam int NREG       = 32;
   localparam int STARVE_MAX = 4;
   localparam logic [ADDR_W-1:0] REG_ZERO = '0;
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/rf_wr_skid.sv
// rf_wr_skid: 1-entry MDU result buffer with valid/ready, WAW kill and starve counter
module rf_wr_skid
   import rf_pkg::*;
#(
   parameter int SMAX = STARVE_MAX
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_en,
   input  logic              i_mdu_valid,
   input  logic [ADDR_W-1:0] i_mdu_no,
   input  logic [DATA_W-1:0] i_mdu_data,
   input  logic              i_wb_wr,
   input  logic [ADDR_W-1:0] i_wb_no,
   output logic              o_ready,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_no,
   output logic [DATA_W-1:0] o_data,
   output logic              o_hold
);
   localparam int SW = $clog2(SMAX + 1);
   localparam logic [SW-1:0] SMAX_V = SW'(SMAX);
   logic          r_valid;
   logic [ADDR_W-1:0] r_no;
   logic [DATA_W-1:0] r_data;
   logic [SW-1:0] r_starve;
   logic          w_accept, w_kill, w_drain, w_starved;
   assign o_ready   = i_en && !r_valid;
   assign w_accept  = i_mdu_valid && o_ready;
   assign w_kill    = r_valid && i_wb_wr && i_wb_no == r_no;
   assign w_drain   = r_valid && !i_wb_wr;
   assign w_starved = r_valid && i_wb_wr && !w_kill;
   assign o_valid   = r_valid;
   assign o_no      = r_no;
   assign o_data    = r_data;
   assign o_hold    = r_starve == SMAX_V;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid  <= 1'b0;
         r_starve <= '0;
      end else begin
         if (w_accept) begin
            r_valid <= i_mdu_no != REG_ZERO;
            r_no    <= i_mdu_no;
            r_data  <= i_mdu_data;
         end else if (w_kill || w_drain) begin
            r_valid <= 1'b0;
         end
         // saturate so a misbehaving pipeline cannot wrap the hold off
         r_starve <= w_starved ? (o_hold ? r_starve : r_starve + 1'b1) : '0;
      end
   end
endmodule

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: register-file write port sequencer (init clear, WB/MDU
// arbitration, stall generation)
module regfile_port_ctrl
   import rf_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_no,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              mdu_valid,
   input  logic [ADDR_W-1:0] mdu_no,
   input  logic [DATA_W-1:0] mdu_data,
   output logic              mdu_ready,
   input  logic [ADDR_W-1:0] rd1_no,
   input  logic [ADDR_W-1:0] rd2_no,
   output logic              rf_reg_write,
   output logic [ADDR_W-1:0] rf_reg_no_in,
   output logic [DATA_W-1:0] rf_reg_data_in,
   output logic              init_busy,
   output logic              stall_req,
   output logic              err_wb_drop
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);
   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_err;
   logic              w_init, w_run, w_wb_wr, w_buf;
   logic              w_buf_valid, w_hold;
   logic [ADDR_W-1:0] w_buf_no;
   logic [DATA_W-1:0] w_buf_data;
   assign w_init  = rst_n && r_state == ST_INIT;
   assign w_run   = rst_n && r_state == ST_RUN;
   assign w_wb_wr = w_run && wb_we && wb_no != REG_ZERO;
   assign w_buf   = w_run && w_buf_valid;
   rf_wr_skid #(.SMAX(STARVE_MAX)) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (w_run),
      .i_mdu_valid(mdu_valid),
      .i_mdu_no   (mdu_no),
      .i_mdu_data (mdu_data),
      .i_wb_wr    (w_wb_wr),
      .i_wb_no    (wb_no),
      .o_ready    (mdu_ready),
      .o_valid    (w_buf_valid),
      .o_no       (w_buf_no),
      .o_data     (w_buf_data),
      .o_hold     (w_hold)
   );
   // WB has fixed priority; the buffer only gets the port when WB is idle
   always_comb begin
      rf_reg_write   = w_init || w_wb_wr || w_buf;
      rf_reg_no_in   = w_init ? r_cnt : w_wb_wr ? wb_no : w_buf ? w_buf_no : '0;
      rf_reg_data_in = w_wb_wr ? wb_data : w_buf ? w_buf_data : '0;
      init_busy      = !rst_n || r_state == ST_INIT;
      stall_req      = init_busy || w_hold ||
                       (w_buf_valid && w_buf_no != REG_ZERO &&
                        (rd1_no == w_buf_no || rd2_no == w_buf_no));
   end
   assign err_wb_drop = r_err;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
         r_cnt   <= ADDR_W'(1);
         r_err   <= 1'b0;
      end else if (r_state == ST_INIT) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == LAST) r_state <= ST_RUN;
         if (wb_we) r_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// tb_regfile_port_ctrl: directed + random stimulus against a queue-based model
module tb_regfile_port_ctrl;
   import rf_pkg::*;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic              rst_n, wb_we, mdu_valid, mdu_ready;
   logic [ADDR_W-1:0] wb_no, mdu_no, rd1_no, rd2_no, rf_reg_no_in;
   logic [DATA_W-1:0] wb_data, mdu_data, rf_reg_data_in;
   logic              rf_reg_write, init_busy, stall_req, err_wb_drop;
   regfile_port_ctrl dut (
      .clk(clk), .rst_n(rst_n), .wb_we(wb_we), .wb_no(wb_no), .wb_data(wb_data),
      .mdu_valid(mdu_valid), .mdu_no(mdu_no), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
      .rd1_no(rd1_no), .rd2_no(rd2_no), .rf_reg_write(rf_reg_write),
      .rf_reg_no_in(rf_reg_no_in), .rf_reg_data_in(rf_reg_data_in),
      .init_busy(init_busy), .stall_req(stall_req), .err_wb_drop(err_wb_drop)
   );
   int tests = 0;
   int fails = 0;
   int init_left = 0;
   int wait_c = 0;
   logic err_m = 1'b0;
   logic [ADDR_W-1:0] p_no[$];
   logic [DATA_W-1:0] p_data[$];
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic cyc();
      logic wbw, e_wr, pend;
      logic [31:0] e_no, e_data;
      #1;
      wbw  = wb_we && wb_no != 0;
      pend = p_no.size() > 0;
      if (!rst_n) begin
         e_wr = 0; e_no = 0; e_data = 0;
         chk("ready_rst", 32'(mdu_ready), 32'd0);
         chk("busy_rst", 32'(init_busy), 32'd1);
         chk("stall_rst", 32'(stall_req), 32'd1);
      end else if (init_left > 0) begin
         e_wr = 1; e_no = 32'(NREG - init_left); e_data = 0;
         chk("ready_init", 32'(mdu_ready), 32'd0);
         chk("busy_init", 32'(init_busy), 32'd1);
         chk("stall_init", 32'(stall_req), 32'd1);
         chk("err_init", 32'(err_wb_drop), 32'(err_m));
      end else begin
         e_wr   = wbw || pend;
         e_no   = wbw ? 32'(wb_no) : pend ? 32'(p_no[0]) : 32'd0;
         e_data = wbw ? wb_data : pend ? p_data[0] : 32'd0;
         chk("ready_run", 32'(mdu_ready), 32'(!pend));
         chk("busy_run", 32'(init_busy), 32'd0);
         chk("stall_run", 32'(stall_req),
             32'(wait_c == STARVE_MAX || (pend && (rd1_no == p_no[0] || rd2_no == p_no[0]))));
         chk("err_run", 32'(err_wb_drop), 32'(err_m));
      end
      chk("rf_write", 32'(rf_reg_write), 32'(e_wr));
      chk("rf_no", 32'(rf_reg_no_in), e_no);
      chk("rf_data", rf_reg_data_in, e_data);
      @(posedge clk);
      if (!rst_n) begin
         init_left = NREG - 1; wait_c = 0; err_m = 0;
         p_no.delete(); p_data.delete();
      end else if (init_left > 0) begin
         if (wb_we) err_m = 1;
         init_left--;
      end else if (pend) begin
         if (wbw && wb_no != p_no[0]) wait_c = wait_c < STARVE_MAX ? wait_c + 1 : wait_c;
         else begin
            void'(p_no.pop_front()); void'(p_data.pop_front()); wait_c = 0;
         end
      end else begin
         wait_c = 0;
         if (mdu_valid && mdu_no != 0) begin
            p_no.push_back(mdu_no); p_data.push_back(mdu_data);
         end
      end
      @(negedge clk);
   endtask
   task automatic mdu(input logic [ADDR_W-1:0] n, input logic [DATA_W-1:0] d);
      mdu_valid = 1; mdu_no = n; mdu_data = d;
      cyc();
      mdu_valid = 0;
   endtask
   initial begin
      rst_n = 0; wb_we = 0; wb_no = 0; wb_data = 0; mdu_valid = 0; mdu_no = 0;
      mdu_data = 0; rd1_no = 0; rd2_no = 0;
      @(negedge clk);
      cyc(); cyc();
      rst_n = 1;
      repeat (31) cyc();
      chk("busy_after_clear", 32'(init_busy), 32'd0);
      wb_we = 1; wb_no = 5; wb_data = 32'hDEADBEEF;
      cyc();
      wb_no = 0;
      cyc();
      wb_we = 0;
      mdu(7, 32'h1234);
      chk("ready_low_pending", 32'(mdu_ready), 32'd0);
      cyc(); cyc();
      mdu(7, 32'h5678);
      rd1_no = 7; wb_we = 1; wb_no = 3; wb_data = 32'h33;
      cyc(); cyc();
      wb_no = 7; wb_data = 32'hAAAA5555;
      cyc();
      wb_we = 0; rd1_no = 0;
      cyc();
      mdu(11, 32'hB0B0);
      wb_we = 1; wb_no = 9; wb_data = 32'h99;
      repeat (4) cyc();
      chk("starve_hold", 32'(stall_req), 32'd1);
      wb_we = 0;
      cyc(); cyc();
      mdu(12, 32'hC0C0);
      rst_n = 0;
      cyc();
      rst_n = 1; wb_we = 1; wb_no = 4;
      repeat (31) cyc();
      wb_we = 0;
      cyc();
      chk("err_sticky", 32'(err_wb_drop), 32'd1);
      repeat (600) begin
         rst_n     = $urandom_range(0, 199) != 0;
         wb_we     = wait_c < STARVE_MAX && $urandom_range(0, 1) == 1;
         wb_no     = ADDR_W'($urandom_range(0, 7));
         wb_data   = $urandom;
         mdu_valid = $urandom_range(0, 1) == 1;
         mdu_no    = ADDR_W'($urandom_range(0, 7));
         mdu_data  = $urandom;
         rd1_no    = ADDR_W'($urandom_range(0, 7));
         rd2_no    = ADDR_W'($urandom_range(0, 7));
         cyc();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
